// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: majority-voted sampling, optional parity,
// configurable stop length, parity/framing error flags and break detection.
module uart_rx_ext #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OS         = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  // Wide enough for both the per-bit count (OS-1) and the stop-phase count.
  localparam int unsigned SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int unsigned SW   = $clog2(SMAX);
  localparam int unsigned NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_H_C0   = SW'(OS/2 - 3);
  localparam logic [SW-1:0] S_H_C1   = SW'(OS/2 - 2);
  localparam logic [SW-1:0] S_H_VOTE = SW'(OS/2 - 1);
  localparam logic [SW-1:0] S_F_C0   = SW'(OS - 3);
  localparam logic [SW-1:0] S_F_C1   = SW'(OS - 2);
  localparam logic [SW-1:0] S_F_VOTE = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);
  localparam logic          PAR_ON   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_sync;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] sr;
  logic            pbit, stop_smp, cap0, cap1;

  logic [SW-1:0]   pt0, pt1, pt_vote;
  logic            vote, stop_v;
  logic            s_clr, s_inc, n_clr, n_inc;
  logic            shift_en, pbit_en, stop_en, done_en;
  logic            pe_next, fe_next, bd_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // START votes around the half-bit point; all later phases vote at bit end.
  always_comb begin
    if (state == START) begin
      pt0     = S_H_C0;
      pt1     = S_H_C1;
      pt_vote = S_H_VOTE;
    end else begin
      pt0     = S_F_C0;
      pt1     = S_F_C1;
      pt_vote = S_F_VOTE;
    end
  end

  assign vote   = (cap0 & cap1) | (cap0 & rx_sync) | (cap1 & rx_sync);
  // When the stop vote and the stop-phase end coincide, use the live vote.
  assign stop_v = (s == S_F_VOTE) ? vote : stop_smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (!rx_sync) state_next = START;
      START:    if (s_tick && s == pt_vote) state_next = vote ? IDLE : DATA;
      DATA:     if (s_tick && s == S_F_VOTE && n == N_LAST)
                  state_next = PAR_ON ? PARITY : STOP;
      PARITY:   if (s_tick && s == S_F_VOTE) state_next = STOP;
      STOP:     if (s_tick && s == S_STOP) state_next = stop_v ? IDLE : BRK_WAIT;
      BRK_WAIT: if (rx_sync) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    s_clr    = 1'b0;
    s_inc    = 1'b0;
    n_clr    = 1'b0;
    n_inc    = 1'b0;
    shift_en = 1'b0;
    pbit_en  = 1'b0;
    stop_en  = 1'b0;
    done_en  = 1'b0;
    unique case (state)
      IDLE: s_clr = !rx_sync;
      START:
        if (s_tick) begin
          if (s == pt_vote) begin
            s_clr = 1'b1;
            n_clr = 1'b1;
          end else s_inc = 1'b1;
        end
      DATA:
        if (s_tick) begin
          if (s == S_F_VOTE) begin
            s_clr    = 1'b1;
            shift_en = 1'b1;
            n_inc    = (n != N_LAST);
          end else s_inc = 1'b1;
        end
      PARITY:
        if (s_tick) begin
          if (s == S_F_VOTE) begin
            s_clr   = 1'b1;
            pbit_en = 1'b1;
          end else s_inc = 1'b1;
        end
      STOP:
        if (s_tick) begin
          stop_en = (s == S_F_VOTE);
          if (s == S_STOP) begin
            s_clr   = 1'b1;
            done_en = 1'b1;
          end else s_inc = 1'b1;
        end
      default: ;
    endcase
  end

  always_comb begin
    pe_next = PAR_ON & ((^sr) ^ pbit ^ PAR_ODD);
    fe_next = ~stop_v;
    bd_next = (sr == '0) & (~pbit | ~PAR_ON) & ~stop_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s            <= '0;
      n            <= '0;
      sr           <= '0;
      pbit         <= 1'b0;
      stop_smp     <= 1'b0;
      cap0         <= 1'b0;
      cap1         <= 1'b0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      if (s_clr)      s <= '0;
      else if (s_inc) s <= s + 1'b1;
      if (n_clr)      n <= '0;
      else if (n_inc) n <= n + 1'b1;
      if (s_tick && s == pt0) cap0 <= rx_sync;
      if (s_tick && s == pt1) cap1 <= rx_sync;
      if (shift_en) sr       <= {vote, sr[DBIT-1:1]};
      if (pbit_en)  pbit     <= vote;
      if (stop_en)  stop_smp <= vote;
      rx_done_tick <= done_en;
      if (done_en) begin
        dout       <= sr;
        parity_err <= pe_next;
        frame_err  <= fe_next;
        break_det  <= bd_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: three configurations (8N1, 7E1, 9-bit/OS=8),
// expected frames queued at send time and checked by per-instance monitors.
module tb_uart_rx_ext;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] tdiv = 2'd0;
  logic       s_tick;
  logic       rx_l [3];

  logic       done_a, pe_a, fe_a, bd_a;
  logic [7:0] dout_a;
  logic       done_b, pe_b, fe_b, bd_b;
  logic [6:0] dout_b;
  logic       done_c, pe_c, fe_c, bd_c;
  logic [8:0] dout_c;

  int   checks   = 0;
  int   failures = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign s_tick = (tdiv == 2'd3);

  uart_rx_ext #(.DBIT(8)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .s_tick(s_tick),
    .rx_done_tick(done_a), .dout(dout_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a));

  uart_rx_ext #(.DBIT(7), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .s_tick(s_tick),
    .rx_done_tick(done_b), .dout(dout_b),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b));

  uart_rx_ext #(.DBIT(9), .OS(8), .SB_TICK(16)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .s_tick(s_tick),
    .rx_done_tick(done_c), .dout(dout_c),
    .parity_err(pe_c), .frame_err(fe_c), .break_det(bd_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [8:0] d, input logic pe,
                      input logic fe, input logic bd);
    exp_t e;
    e = '{d: d, pe: pe, fe: fe, bd: bd};
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic check_pulse(input int idx, input exp_t act);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    case (idx)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL unexpected_done dut%0d got dout=%h pe=%b fe=%b bd=%b",
               idx, act.d, act.pe, act.fe, act.bd);
    end else if (act !== e) begin
      failures++;
      $display("FAIL frame dut%0d got dout=%h pe=%b fe=%b bd=%b expected dout=%h pe=%b fe=%b bd=%b",
               idx, act.d, act.pe, act.fe, act.bd, e.d, e.pe, e.fe, e.bd);
    end
  endtask

  always @(negedge clk) if (done_a === 1'b1) check_pulse(0, exp_t'({1'b0, dout_a, pe_a, fe_a, bd_a}));
  always @(negedge clk) if (done_b === 1'b1) check_pulse(1, exp_t'({2'b0, dout_b, pe_b, fe_b, bd_b}));
  always @(negedge clk) if (done_c === 1'b1) check_pulse(2, exp_t'({dout_c, pe_c, fe_c, bd_c}));

  // Called at a falling clk edge; holds the line level for clks cycles.
  task automatic drive(input int idx, input logic b, input int clks);
    rx_l[idx] = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [8:0] word, input int nd,
                            input bit par_on, input logic pbit, input logic stopb,
                            input int stop_bits, input int idle_bits, input int os,
                            input int glitch_bit);
    int bp;
    bp = os * 4;
    drive(idx, 1'b0, bp);
    for (int i = 0; i < nd; i++) begin
      if (i == glitch_bit) begin
        drive(idx, word[i], 28);
        drive(idx, ~word[i], 4);
        drive(idx, word[i], bp - 32);
      end else begin
        drive(idx, word[i], bp);
      end
    end
    if (par_on) drive(idx, pbit, bp);
    drive(idx, stopb, bp * stop_bits);
    if (idle_bits > 0) drive(idx, 1'b1, bp * idle_bits);
    else rx_l[idx] = 1'b1;
  endtask

  initial begin
    #1ms;
    failures++;
    $display("FAIL watchdog simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) rx_l[i] = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_done_a", 32'(done_a), 32'd0);
    chk("reset_dout_a", 32'(dout_a), 32'd0);
    chk("reset_flags_a", 32'({pe_a, fe_a, bd_a}), 32'd0);
    chk("reset_done_b", 32'(done_b), 32'd0);
    chk("reset_dout_c", 32'(dout_c), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 basic frame
    push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1, 2, 16, -1);

    // 7E1: 0x41 has two ones, so parity 1 is wrong and 0 is right
    push(1, 9'h041, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1, 2, 16, -1);
    push(1, 9'h041, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h041, 7, 1'b1, 1'b0, 1'b1, 1, 2, 16, -1);

    // false start: 3-tick low glitch, then a spike inside data bit 2
    drive(0, 1'b0, 12);
    drive(0, 1'b1, 128);
    chk("false_start_dout_held", 32'(dout_a), 32'h0A5);
    chk("false_start_no_done", 32'(done_a), 32'd0);
    push(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1, 2, 16, 2);

    // framing error, then a long break with a single pulse
    push(0, 9'h055, 1'b0, 1'b1, 1'b0);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1, 2, 16, -1);
    push(0, 9'h000, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 64 * 20);
    drive(0, 1'b1, 64 * 2);
    push(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1, 2, 16, -1);

    // reset during data bit 4 of 0xFF
    drive(0, 1'b0, 64);
    drive(0, 1'b1, 64 * 4 + 32);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midframe_reset_dout", 32'(dout_a), 32'd0);
    chk("midframe_reset_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    drive(0, 1'b1, 64 * 8);
    push(0, 9'h012, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1, 2, 16, -1);

    // 9-bit, OS=8, two stop bits, back to back
    push(2, 9'h1AB, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h1AB, 9, 1'b0, 1'b0, 1'b1, 2, 0, 8, -1);
    push(2, 9'h054, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h054, 9, 1'b0, 1'b0, 1'b1, 2, 2, 8, -1);

    repeat (200) @(negedge clk);
    chk("pending_a", 32'(q0.size()), 32'd0);
    chk("pending_b", 32'(q1.size()), 32'd0);
    chk("pending_c", 32'(q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
